hack_control_unit: RTL and testbench
====================================

Name: hack_control_unit

Overview:
Multi-cycle Hack instruction sequencer sitting directly upstream of the 16-bit ALU.
- Accepts instructions over a valid/ready handshake and decodes A- and C-instructions.
- Holds the A, D and PC registers, fetches the M operand from data memory and drives the ALU operands and six control bits.
- Samples the ALU result and flags, writes back the destinations and resolves jumps.

Parameters:
PC_WIDTH, 15, width of program counter; jump target is A[PC_WIDTH-1:0]; PC wraps modulo 2^PC_WIDTH.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high reset.
instr_valid  in  1  instruction word available.
instr  in  16  instruction word.
instr_ready  out  1  unit accepts instr this cycle.
pc  out  PC_WIDTH  address of next instruction to fetch.
mem_re  out  1  data-memory read request.
mem_rvalid  in  1  read data valid.
mem_rdata  in  16  read data (M).
mem_we  out  1  data-memory write strobe.
mem_addr  out  16  data-memory address (always current A).
mem_wdata  out  16  write data (ALU result).
alu_x  out  16  ALU x operand (D).
alu_y  out  16  ALU y operand (A or M).
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU controls = instr_q[11:6] in that order.
alu_out  in  16  ALU result.
alu_zr  in  1  ALU zero flag.
alu_ng  in  1  ALU negative flag.
halted  out  1  see Optional Feature.

Behaviour:
- Reset (sync, high): A=0, D=0, M_q=0, pc=0, instr_q=0, state=FETCH. Outputs during and after reset: mem_re=0, mem_we=0, halted=0. instr_ready is 0 in the reset cycle.
- State FETCH: instr_ready=1. On instr_valid, latch instr into instr_q and go to DECODE; otherwise hold.
- State DECODE, instr_q[15]=0 (A-instruction): A<=instr_q, pc<=pc+1, go to FETCH. Total 2 cycles.
- State DECODE, C-instruction with a-bit instr_q[12]=1: go to MEMWAIT. With a-bit 0: go to EXEC.
- State MEMWAIT: mem_re=1, mem_addr=A, held until mem_rvalid. In the mem_rvalid cycle, M_q<=mem_rdata and go to EXEC. Unbounded wait permitted.
- State EXEC:
  - Operands: alu_x=D; alu_y=M_q if a-bit is 1, else A.
  - Destination bits: d1=instr_q[5] writes A, d2=instr_q[4] writes D, d3=instr_q[3] writes memory. When d3=1, mem_we=1 for exactly this cycle, with mem_addr=old A and mem_wdata=alu_out.
  - Jump condition: (j1=instr_q[2] & ng) | (j2=instr_q[1] & zr) | (j3=instr_q[0] & ~ng & ~zr).
  - PC update: if the jump condition holds, pc<=old A[PC_WIDTH-1:0]; else pc<=pc+1. Then go to FETCH.
  - Simultaneous A write and jump: the jump target and mem_addr use A before the write. A takes alu_out at the end of EXEC.
  - Latency: 3 cycles without M; 4+N cycles with M, where N is the number of mem_rvalid wait cycles.
- Outside EXEC: mem_we=0. Outside MEMWAIT: mem_re=0.
- ALU controls and operands are combinational from instr_q, A, D and M_q in every state. They are only sampled in EXEC.
- instr[14:13] is ignored.
- pc at 2^PC_WIDTH-1 increments to 0.
- Reset asserted in any state, including MEMWAIT with a read outstanding, returns to FETCH next cycle. A late mem_rvalid after reset is ignored.

Optional Feature:
Macro HACK_HALT_DETECT_EN.
- Defined: in EXEC, a taken jump with target equal to the current pc (the canonical end-of-program loop) sets halted=1 and enters state HALT. In HALT: instr_ready=0, no memory traffic, pc frozen. Only reset leaves HALT.
- Not defined: no HALT state; halted is tied to 0 and the self-jump loops normally.

Test Plan:
1. Reset, feed @21 -> after 2 cycles A=21, pc=1, no mem_re/mem_we.
2. @5, then D=A (0xEC10) with alu_out model returning 5 -> D=5, pc=2, mem_we never asserted.
3. @100, then M=D+1 (0xE7C8), D=7 -> exactly one mem_we cycle with mem_addr=100, mem_wdata=8; pc=2.
4. @100, then D=M (0xFC10); mem_rvalid delayed 3 cycles with mem_rdata=0x1234 -> mem_re held for 4 cycles, D=0x1234.
5. @40, then AM=-1;JLT (0xEEAC) -> ALU returns 0xFFFF with ng=1; pc=40 (old A); A=0xFFFF; mem_addr=40 on the write.
6. Reset asserted mid-MEMWAIT, then mem_rvalid pulses -> state FETCH, A=D=pc=0, mem_re=0. With HACK_HALT_DETECT_EN: @2 at pc=2, then 0;JMP -> halted=1 and instr_ready stays 0.

Source files
------------

// File: rtl/hack_control_unit.sv
// Multi-cycle Hack sequencer: holds A/D/PC, fetches M, drives the ALU and resolves jumps.
// Optional end-of-program halt detection is enabled with `define HACK_HALT_DETECT_EN.
module hack_control_unit #(
   parameter int PC_WIDTH = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                instr_valid,
   input  logic [15:0]         instr,
   output logic                instr_ready,
   output logic [PC_WIDTH-1:0] pc,
   output logic                mem_re,
   input  logic                mem_rvalid,
   input  logic [15:0]         mem_rdata,
   output logic                mem_we,
   output logic [15:0]         mem_addr,
   output logic [15:0]         mem_wdata,
   output logic [15:0]         alu_x,
   output logic [15:0]         alu_y,
   output logic                alu_zx,
   output logic                alu_nx,
   output logic                alu_zy,
   output logic                alu_ny,
   output logic                alu_f,
   output logic                alu_no,
   input  logic [15:0]         alu_out,
   input  logic                alu_zr,
   input  logic                alu_ng,
   output logic                halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_MEMWAIT,
      S_EXEC
`ifdef HACK_HALT_DETECT_EN
      , S_HALT
`endif
   } state_t;

   state_t              r_state;
   logic [15:0]         r_instr;
   logic [15:0]         r_a;
   logic [15:0]         r_d;
   logic [15:0]         r_m;
   logic [PC_WIDTH-1:0] r_pc;
`ifdef HACK_HALT_DETECT_EN
   logic                r_halted;
`endif

   logic                w_jump;
   logic [PC_WIDTH-1:0] w_target;
   logic [PC_WIDTH-1:0] w_pc_inc;

   assign w_jump   = (r_instr[2] & alu_ng) | (r_instr[1] & alu_zr) |
                     (r_instr[0] & ~alu_ng & ~alu_zr);
   assign w_target = r_a[PC_WIDTH-1:0];
   assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

   // Handshake/strobes are gated by reset so nothing leaks out during the reset cycle.
   assign instr_ready = (r_state == S_FETCH) && !reset;
   assign mem_re      = (r_state == S_MEMWAIT) && !reset;
   assign mem_we      = (r_state == S_EXEC) && r_instr[3] && !reset;
   assign mem_addr    = r_a;
   assign mem_wdata   = alu_out;
   assign pc          = r_pc;

   assign alu_x  = r_d;
   assign alu_y  = r_instr[12] ? r_m : r_a;
   assign alu_zx = r_instr[11];
   assign alu_nx = r_instr[10];
   assign alu_zy = r_instr[9];
   assign alu_ny = r_instr[8];
   assign alu_f  = r_instr[7];
   assign alu_no = r_instr[6];

`ifdef HACK_HALT_DETECT_EN
   assign halted = r_halted;
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_instr  <= '0;
         r_a      <= '0;
         r_d      <= '0;
         r_m      <= '0;
         r_pc     <= '0;
`ifdef HACK_HALT_DETECT_EN
         r_halted <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_FETCH: begin
               if (instr_valid) begin
                  r_instr <= instr;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!r_instr[15]) begin
                  r_a     <= r_instr;
                  r_pc    <= w_pc_inc;
                  r_state <= S_FETCH;
               end else if (r_instr[12]) begin
                  r_state <= S_MEMWAIT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_MEMWAIT: begin
               if (mem_rvalid) begin
                  r_m     <= mem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               // Jump target and write address use A before its own update lands here.
               if (r_instr[5]) r_a <= alu_out;
               if (r_instr[4]) r_d <= alu_out;
               r_pc <= w_jump ? w_target : w_pc_inc;
`ifdef HACK_HALT_DETECT_EN
               if (w_jump && (w_target == r_pc)) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  r_state  <= S_FETCH;
               end
`else
               r_state <= S_FETCH;
`endif
            end
`ifdef HACK_HALT_DETECT_EN
            S_HALT: r_state <= S_HALT;
`endif
            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_hack_control_unit.sv
// Scoreboard bench for hack_control_unit: a Hack ALU model sits on the ALU ports,
// a responder serves memory reads, and monitors check fetch-boundary state and writes.
module tb_hack_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic [14:0] pc;
   logic        mem_re;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] alu_x, alu_y;
   logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
   logic [15:0] alu_out;
   logic        alu_zr, alu_ng;
   logic        halted;

   always #5 clk = ~clk;

   hack_control_unit #(.PC_WIDTH(15)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .pc(pc), .mem_re(mem_re), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
      .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
      .alu_zr(alu_zr), .alu_ng(alu_ng), .halted(halted)
   );

   function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic zx, input logic nx, input logic zy,
                                            input logic ny, input logic f, input logic no);
      logic [15:0] a, b, r;
      a = zx ? 16'h0000 : x;
      if (nx) a = ~a;
      b = zy ? 16'h0000 : y;
      if (ny) b = ~b;
      r = f ? (a + b) : (a & b);
      if (no) r = ~r;
      return r;
   endfunction

   assign alu_out = hack_alu(alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no);
   assign alu_zr  = (alu_out == 16'h0000);
   assign alu_ng  = alu_out[15];

   typedef struct packed {
      logic [14:0] pc;
      logic [15:0] a;
      logic [15:0] d;
   } fexp_t;
   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wexp_t;

   fexp_t fq[$];
   wexp_t wq[$];
   int    n_tests = 0;
   int    n_fail = 0;
   int    re_cnt = 0;
   int    we_cnt = 0;
   int    rv_delay = 0;
   logic [15:0] rv_data = '0;
   logic  rv_pulse = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_fetch(input logic [14:0] p, input logic [15:0] a, input logic [15:0] d);
      fexp_t e;
      e.pc = p; e.a = a; e.d = d;
      fq.push_back(e);
   endtask

   task automatic exp_write(input logic [15:0] addr, input logic [15:0] data);
      wexp_t e;
      e.addr = addr; e.data = data;
      wq.push_back(e);
   endtask

   // Memory read responder: valid after rv_delay wait cycles of mem_re, or on a forced pulse.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (rv_pulse) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_data;
         end else if (mem_re) begin
            if (cnt == rv_delay) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rv_data;
               cnt = 0;
            end else begin
               mem_rvalid = 1'b0;
               cnt++;
            end
         end else begin
            mem_rvalid = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: each return to FETCH pops an expected {pc, A, D}; each write pops {addr, data}.
   initial begin
      logic prev_rdy;
      fexp_t f;
      wexp_t w;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (instr_ready && !prev_rdy) begin
            if (fq.size() == 0) begin
               check("fetch_unexpected", 32'd1, 32'd0);
            end else begin
               f = fq.pop_front();
               check("fetch_pc", {17'd0, pc}, {17'd0, f.pc});
               check("fetch_A", {16'd0, mem_addr}, {16'd0, f.a});
               check("fetch_D", {16'd0, alu_x}, {16'd0, f.d});
            end
         end
         if (mem_we) begin
            we_cnt++;
            if (wq.size() == 0) begin
               check("write_unexpected", {16'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               w = wq.pop_front();
               check("write_addr", {16'd0, mem_addr}, {16'd0, w.addr});
               check("write_data", {16'd0, mem_wdata}, {16'd0, w.data});
            end
         end
         if (mem_re) re_cnt++;
         prev_rdy = instr_ready;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (instr_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check(name, 32'd0, 32'd1);
   endtask

   task automatic send(input logic [15:0] w);
      wait_ready("ready_timeout");
      instr       = w;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
   endtask

   task automatic do_reset();
      step();
      reset       = 1'b1;
      instr_valid = 1'b0;
      exp_fetch(15'd0, 16'd0, 16'd0);
      step();
      check("rst_ready", {31'd0, instr_ready}, 32'd0);
      check("rst_mem_re", {31'd0, mem_re}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int re0, we0;
      // 1: @21
      do_reset();
      re0 = re_cnt; we0 = we_cnt;
      exp_fetch(15'd1, 16'd21, 16'd0);
      send(16'h0015);
      wait_ready("t1_done");
      check("t1_re_count", re_cnt - re0, 32'd0);
      check("t1_we_count", we_cnt - we0, 32'd0);

      // 2: @5, D=A
      do_reset();
      we0 = we_cnt;
      exp_fetch(15'd1, 16'd5, 16'd0);
      send(16'h0005);
      exp_fetch(15'd2, 16'd5, 16'd5);
      send(16'hEC10);
      wait_ready("t2_done");
      check("t2_we_count", we_cnt - we0, 32'd0);

      // 3: D=7 then @100, M=D+1
      do_reset();
      we0 = we_cnt;
      exp_fetch(15'd1, 16'd7, 16'd0);
      send(16'h0007);
      exp_fetch(15'd2, 16'd7, 16'd7);
      send(16'hEC10);
      exp_fetch(15'd3, 16'd100, 16'd7);
      send(16'h0064);
      exp_write(16'd100, 16'd8);
      exp_fetch(15'd4, 16'd100, 16'd7);
      send(16'hE7C8);
      wait_ready("t3_done");
      check("t3_we_count", we_cnt - we0, 32'd1);

      // 4: @100, D=M with 3 wait cycles
      do_reset();
      rv_delay = 3; rv_data = 16'h1234;
      exp_fetch(15'd1, 16'd100, 16'd0);
      send(16'h0064);
      re0 = re_cnt;
      exp_fetch(15'd2, 16'd100, 16'h1234);
      send(16'hFC10);
      wait_ready("t4_done");
      check("t4_re_count", re_cnt - re0, 32'd4);
      rv_delay = 0;

      // 5: @40, AM=-1;JLT, then D;JGT (not taken), D;JEQ (to 0x7FFF), @3 (pc wraps)
      do_reset();
      exp_fetch(15'd1, 16'd40, 16'd0);
      send(16'h0028);
      exp_write(16'd40, 16'hFFFF);
      exp_fetch(15'd40, 16'hFFFF, 16'd0);
      send(16'hEEAC);
      exp_fetch(15'd41, 16'hFFFF, 16'd0);
      send(16'hE301);
      exp_fetch(15'h7FFF, 16'hFFFF, 16'd0);
      send(16'hE302);
      exp_fetch(15'd0, 16'd3, 16'd0);
      send(16'h0003);
      wait_ready("t5_done");

      // 6: reset while a read is outstanding, then a late rvalid
      do_reset();
      rv_delay = 1000; rv_data = 16'hBEEF;
      exp_fetch(15'd1, 16'd9, 16'd0);
      send(16'h0009);
      exp_fetch(15'd2, 16'd9, 16'd9);
      send(16'hEC10);
      exp_fetch(15'd3, 16'd100, 16'd9);
      send(16'h0064);
      send(16'hFC10);
      step(); step(); step();
      check("t6_re_pending", {31'd0, mem_re}, 32'd1);
      do_reset();
      step();
      rv_pulse = 1'b1;
      step();
      rv_pulse = 1'b0;
      step();
      check("t6_re_after", {31'd0, mem_re}, 32'd0);
      check("t6_ready_after", {31'd0, instr_ready}, 32'd1);
      check("t6_pc_after", {17'd0, pc}, 32'd0);
      check("t6_A_after", {16'd0, mem_addr}, 32'd0);
      check("t6_D_after", {16'd0, alu_x}, 32'd0);
      exp_fetch(15'd1, 16'd5, 16'd0);
      send(16'h0005);
      wait_ready("t6_done");
      rv_delay = 0;

      // 7: self-jump at pc=2
      do_reset();
      exp_fetch(15'd1, 16'd2, 16'd0);
      send(16'h0002);
      exp_fetch(15'd2, 16'd2, 16'd0);
      send(16'h0002);
`ifdef HACK_HALT_DETECT_EN
      send(16'hEA87);
      for (int i = 0; i < 6; i++) step();
      check("t7_halted", {31'd0, halted}, 32'd1);
      check("t7_ready", {31'd0, instr_ready}, 32'd0);
      check("t7_pc", {17'd0, pc}, 32'd2);
      check("t7_mem_re", {31'd0, mem_re}, 32'd0);
`else
      exp_fetch(15'd2, 16'd2, 16'd0);
      send(16'hEA87);
      wait_ready("t7_done");
      check("t7_halted", {31'd0, halted}, 32'd0);
`endif

      for (int i = 0; i < 4; i++) step();
      check("drain_fetch_queue", fq.size(), 32'd0);
      check("drain_write_queue", wq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
